// File: rtl/pcs_block_lock_ctrl.sv
// ============================================================================
// pcs_block_lock_ctrl
// ----------------------------------------------------------------------------
// Receive-side 64b/66b block-lock controller. It sits in front of the
// 66b->XGMII decoder and watches the 2-bit sync header of every accepted
// block. While the block boundary is unknown, it asks the gearbox to slip by
// one bit until LOCK_COUNT consecutive good headers are seen. While locked,
// it monitors fixed windows of WINDOW_SIZE headers and drops lock when
// BAD_LIMIT invalid headers land in one window. It also drives the enable
// that gates blocks into the decoder.
//
// Optional feature (compile-time macro PCS_HI_BER_EN):
//   A free-running hi-BER timer of BER_WINDOW cycles counts invalid headers
//   seen while locked (saturating at BER_LIMIT). At every timer expiry,
//   hi_ber_out is set to (count >= BER_LIMIT) and held for the next period.
//   hi_ber_out masks dec_enable_out but never drops lock. Without the macro,
//   hi_ber_out is tied to 0 and no timer or counter logic is built.
//
// Ports
//   rx_clk          in   1  receive clock, the only clock of the block
//   rx_rst          in   1  asynchronous assert, active-high reset
//   hdr_in          in   2  sync header [65:64] of the current 66b block
//   hdr_valid_in    in   1  hdr_in belongs to an accepted block
//   slip_out        out  1  one-cycle pulse: gearbox shifts boundary one bit
//   block_lock_out  out  1  block boundary is locked
//   dec_enable_out  out  1  block_lock_out && !hi_ber_out (registered)
//   slip_count_out  out  8  slips issued since reset, saturating at 8'hFF
//   hi_ber_out      out  1  high bit-error-rate flag
//
// Timing
//   All outputs are registered. Each decision becomes visible in the cycle
//   after the header that caused it. The SLIP state lasts SLIP_WAIT cycles.
//   The first of these cycles carries the slip pulse. Headers that arrive
//   during any SLIP cycle are ignored, because the gearbox output is still
//   settling.
// ============================================================================
module pcs_block_lock_ctrl #(
    parameter int LOCK_COUNT  = 64,
    parameter int WINDOW_SIZE = 64,
    parameter int BAD_LIMIT   = 16,
    parameter int SLIP_WAIT   = 4,
    parameter int BER_WINDOW  = 19531,
    parameter int BER_LIMIT   = 16
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    input  logic [1:0] hdr_in,
    input  logic       hdr_valid_in,
    output logic       slip_out,
    output logic       block_lock_out,
    output logic       dec_enable_out,
    output logic [7:0] slip_count_out,
    output logic       hi_ber_out
);

    // Each counter is sized to hold its own threshold. Every counter is
    // cleared when it reaches that threshold, so none of them can wrap.
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int HDR_W  = $clog2(WINDOW_SIZE + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    // Counter values seen on the cycle *before* the threshold is hit. The
    // decision is made on the header that would take the counter to its
    // threshold.
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'(WINDOW_SIZE - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SLIP     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t            state_reg;
    logic [GOOD_W-1:0] good_cnt_reg;
    logic [HDR_W-1:0]  hdr_cnt_reg;
    logic [BAD_W-1:0]  bad_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              slip_reg;
    logic              block_lock_reg;
    logic              dec_enable_reg;
    logic [7:0]        slip_count_reg;

    logic              hdr_ok;
    logic              lock_acquire;
    logic              lock_loss;
    logic              lock_next;
    logic              hi_ber_next;
    logic [7:0]        slip_count_inc;

    // A legal sync header has exactly one bit set (2'b01 or 2'b10).
    assign hdr_ok = hdr_in[1] ^ hdr_in[0];

    // The lock transitions are pulled out of the FSM so that dec_enable can
    // be registered from the same next-cycle lock value as block_lock_out.
    assign lock_acquire = (state_reg == ST_UNLOCKED) && hdr_valid_in && hdr_ok &&
                          (good_cnt_reg == GOOD_LAST);
    assign lock_loss    = (state_reg == ST_LOCKED) && hdr_valid_in && !hdr_ok &&
                          (bad_cnt_reg == BAD_LAST);
    assign lock_next    = lock_acquire || (block_lock_reg && !lock_loss);

    assign slip_count_inc = (slip_count_reg == 8'hFF) ? 8'hFF : slip_count_reg + 8'd1;

    // ------------------------------------------------------------------------
    // Block-lock state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_reg      <= ST_UNLOCKED;
            good_cnt_reg   <= '0;
            hdr_cnt_reg    <= '0;
            bad_cnt_reg    <= '0;
            wait_cnt_reg   <= '0;
            slip_reg       <= 1'b0;
            block_lock_reg <= 1'b0;
            dec_enable_reg <= 1'b0;
            slip_count_reg <= 8'h00;
        end else begin
            // The slip request is a single-cycle pulse. It is re-armed only
            // on entry to SLIP.
            slip_reg       <= 1'b0;
            block_lock_reg <= lock_next;
            dec_enable_reg <= lock_next && !hi_ber_next;

            case (state_reg)
                ST_UNLOCKED: begin
                    if (hdr_valid_in) begin
                        if (!hdr_ok) begin
                            state_reg      <= ST_SLIP;
                            slip_reg       <= 1'b1;
                            slip_count_reg <= slip_count_inc;
                            good_cnt_reg   <= '0;
                            wait_cnt_reg   <= '0;
                        end else if (good_cnt_reg == GOOD_LAST) begin
                            state_reg    <= ST_LOCKED;
                            good_cnt_reg <= '0;
                            hdr_cnt_reg  <= '0;
                            bad_cnt_reg  <= '0;
                        end else begin
                            good_cnt_reg <= good_cnt_reg + GOOD_W'(1);
                        end
                    end
                end

                ST_SLIP: begin
                    // This state counts clock cycles, not headers. The
                    // gearbox settles in real time, whether or not blocks
                    // are being accepted.
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg    <= ST_UNLOCKED;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end

                ST_LOCKED: begin
                    if (hdr_valid_in) begin
                        if (lock_loss) begin
                            // Loss of lock is checked first. It therefore
                            // wins over a window end on the same header.
                            state_reg      <= ST_SLIP;
                            slip_reg       <= 1'b1;
                            slip_count_reg <= slip_count_inc;
                            hdr_cnt_reg    <= '0;
                            bad_cnt_reg    <= '0;
                            good_cnt_reg   <= '0;
                            wait_cnt_reg   <= '0;
                        end else if (hdr_cnt_reg == HDR_LAST) begin
                            hdr_cnt_reg <= '0;
                            bad_cnt_reg <= '0;
                        end else begin
                            hdr_cnt_reg <= hdr_cnt_reg + HDR_W'(1);
                            if (!hdr_ok) begin
                                bad_cnt_reg <= bad_cnt_reg + BAD_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_reg    <= ST_UNLOCKED;
                    good_cnt_reg <= '0;
                    hdr_cnt_reg  <= '0;
                    bad_cnt_reg  <= '0;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign slip_out       = slip_reg;
    assign block_lock_out = block_lock_reg;
    assign dec_enable_out = dec_enable_reg;
    assign slip_count_out = slip_count_reg;

    // ------------------------------------------------------------------------
    // Hi-BER monitor
    // ------------------------------------------------------------------------
`ifdef PCS_HI_BER_EN
    localparam int BT_W = $clog2(BER_WINDOW + 1);
    localparam int BC_W = $clog2(BER_LIMIT + 1);

    logic [BT_W-1:0] ber_timer_reg;
    logic [BC_W-1:0] ber_cnt_reg;
    logic [BC_W-1:0] ber_cnt_next;
    logic            hi_ber_reg;
    logic            ber_hit;
    logic            ber_expire;

    assign ber_hit      = (state_reg == ST_LOCKED) && hdr_valid_in && !hdr_ok;
    assign ber_expire   = (ber_timer_reg == BT_W'(BER_WINDOW - 1));
    // The count saturates at the limit. Beyond that point, the verdict at
    // expiry cannot change.
    assign ber_cnt_next = (ber_hit && (ber_cnt_reg != BC_W'(BER_LIMIT))) ?
                          ber_cnt_reg + BC_W'(1) : ber_cnt_reg;
    // The header on the expiry cycle still counts toward the closing period.
    assign hi_ber_next  = ber_expire ? (ber_cnt_next >= BC_W'(BER_LIMIT)) : hi_ber_reg;

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            ber_timer_reg <= '0;
            ber_cnt_reg   <= '0;
            hi_ber_reg    <= 1'b0;
        end else begin
            hi_ber_reg <= hi_ber_next;
            if (ber_expire) begin
                ber_timer_reg <= '0;
                ber_cnt_reg   <= '0;
            end else begin
                ber_timer_reg <= ber_timer_reg + BT_W'(1);
                ber_cnt_reg   <= ber_cnt_next;
            end
        end
    end

    assign hi_ber_out = hi_ber_reg;
`else
    // The BER window and limit only shape the optional monitor. They are
    // folded into a sink here so that the default build has no dangling
    // configuration.
    localparam int unused_ber_cfg = BER_WINDOW + BER_LIMIT;

    assign hi_ber_next = 1'b0;
    assign hi_ber_out  = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// ============================================================================
// tb_pcs_block_lock_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for pcs_block_lock_ctrl. A behavioural model tracks
// lock status, window tallies, the settle time after a slip and the slip
// total, using plain integers. A compare process checks every DUT output
// against the model one time unit after each rising edge. Directed scenarios
// add literal expectations at the decision points. Randomized traffic with
// varying error rates and idle cycles exercises the remaining space.
// If PCS_HI_BER_EN is defined, the model also covers the hi-BER monitor,
// with a 100-cycle period.
// ============================================================================
module tb_pcs_block_lock_ctrl;

    localparam int LOCK_COUNT  = 64;
    localparam int WINDOW_SIZE = 64;
    localparam int BAD_LIMIT   = 16;
    localparam int SLIP_WAIT   = 4;
    localparam int BER_LIMIT   = 16;
`ifdef PCS_HI_BER_EN
    localparam int BER_WINDOW  = 100;
`else
    localparam int BER_WINDOW  = 19531;
`endif

    logic       rx_clk;
    logic       rx_rst;
    logic [1:0] hdr_in;
    logic       hdr_valid_in;
    logic       slip_out;
    logic       block_lock_out;
    logic       dec_enable_out;
    logic [7:0] slip_count_out;
    logic       hi_ber_out;

    pcs_block_lock_ctrl #(
        .LOCK_COUNT  (LOCK_COUNT),
        .WINDOW_SIZE (WINDOW_SIZE),
        .BAD_LIMIT   (BAD_LIMIT),
        .SLIP_WAIT   (SLIP_WAIT),
        .BER_WINDOW  (BER_WINDOW),
        .BER_LIMIT   (BER_LIMIT)
    ) dut (
        .rx_clk         (rx_clk),
        .rx_rst         (rx_rst),
        .hdr_in         (hdr_in),
        .hdr_valid_in   (hdr_valid_in),
        .slip_out       (slip_out),
        .block_lock_out (block_lock_out),
        .dec_enable_out (dec_enable_out),
        .slip_count_out (slip_count_out),
        .hi_ber_out     (hi_ber_out)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int m_lock, m_ignore, m_good, m_win, m_bad, m_slips, m_pulse;
    int m_cyc, m_ber, m_hiber;
    int slip_seen, hiber_seen, lock_drops, prev_lock;

    task automatic model_reset();
        m_lock = 0; m_ignore = 0; m_good = 0; m_win = 0; m_bad = 0;
        m_slips = 0; m_pulse = 0; m_cyc = 0; m_ber = 0; m_hiber = 0;
    endtask

    task automatic start_slip();
        m_pulse  = 1;
        m_slips  = (m_slips < 255) ? m_slips + 1 : 255;
        m_ignore = SLIP_WAIT;    // number of following cycles whose headers are discarded
        m_good   = 0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] h);
        bit ok;
        bit was_locked;
        ok         = (h == 2'b01) || (h == 2'b10);
        was_locked = (m_lock != 0);
        m_pulse    = 0;
        if (m_ignore > 0) begin
            m_ignore--;
        end else if (v) begin
            if (m_lock == 0) begin
                if (ok) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_lock = 1; m_good = 0; m_win = 0; m_bad = 0;
                    end
                end else begin
                    start_slip();
                end
            end else begin
                m_win++;
                if (!ok) m_bad++;
                if (m_bad == BAD_LIMIT) begin
                    m_lock = 0; m_win = 0; m_bad = 0;
                    start_slip();
                end else if (m_win == WINDOW_SIZE) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end
`ifdef PCS_HI_BER_EN
        if (was_locked && v && !ok && m_ber < BER_LIMIT) m_ber++;
        m_cyc++;
        if (m_cyc % BER_WINDOW == 0) begin
            m_hiber = (m_ber >= BER_LIMIT) ? 1 : 0;
            m_ber   = 0;
        end
`else
        if (was_locked) m_cyc++;
`endif
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle compare process
    // ------------------------------------------------------------------------
    initial begin
        model_reset();
        slip_seen = 0; hiber_seen = 0; lock_drops = 0; prev_lock = 0;
        forever begin
            @(posedge rx_clk);
            #1;
            if (rx_rst) model_reset();
            else        model_step(hdr_valid_in, hdr_in);
            chk("slip_out",       slip_out,       m_pulse);
            chk("block_lock_out", block_lock_out, m_lock);
            chk("dec_enable_out", dec_enable_out, ((m_lock != 0) && (m_hiber == 0)) ? 1 : 0);
            chk("slip_count_out", slip_count_out, m_slips);
            chk("hi_ber_out",     hi_ber_out,     m_hiber);
            if (slip_out)   slip_seen++;
            if (hi_ber_out) hiber_seen++;
            if (prev_lock != 0 && !block_lock_out) lock_drops++;
            prev_lock = block_lock_out;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic send(input logic v, input logic [1:0] h);
        hdr_valid_in = v;
        hdr_in       = h;
        @(negedge rx_clk);
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) send(1'b1, (i % 2) ? 2'b10 : 2'b01);
    endtask

    task automatic send_bad();
        send(1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
    endtask

    task automatic maybe_idle();
        logic [1:0] junk;
        junk = 2'($urandom);
        if ($urandom_range(0, 3) == 0) send(1'b0, junk);
    endtask

    task automatic do_reset();
        hdr_valid_in = 1'b0;
        rx_rst       = 1'b1;
        repeat (2) @(negedge rx_clk);
        rx_rst       = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed and random scenarios
    // ------------------------------------------------------------------------
    initial begin
        int s0;
        int d0;
        int h0;
        int found;
        int rate;
        logic       rv;
        logic [1:0] rh;

        rx_rst       = 1'b1;
        hdr_valid_in = 1'b0;
        hdr_in       = 2'b00;
        repeat (3) @(negedge rx_clk);
        chk("rst_slip",  slip_out,       0);
        chk("rst_lock",  block_lock_out, 0);
        chk("rst_dec",   dec_enable_out, 0);
        chk("rst_count", slip_count_out, 0);
        chk("rst_hiber", hi_ber_out,     0);
        rx_rst = 1'b0;

        // 1: 64 clean headers acquire lock in the cycle after the 64th
        s0 = slip_seen;
        send_good(63);
        chk("t1_lock_before", block_lock_out, 0);
        send_good(1);
        chk("t1_lock", block_lock_out, 1);
        chk("t1_dec",  dec_enable_out, 1);
        chk("t1_no_slip", slip_seen - s0, 0);

        // 2: a bad header after 10 good ones -> one slip, 4 ignored, relock
        do_reset();
        s0 = slip_seen;
        send_good(10);
        send(1'b1, 2'b11);
        chk("t2_slip_pulse", slip_out, 1);
        chk("t2_slip_count", slip_count_out, 1);
        repeat (4) send(1'b1, 2'b00);     // would slip again if not ignored
        chk("t2_pulse_single", slip_seen - s0, 1);
        chk("t2_count_held", slip_count_out, 1);
        send_good(63);
        chk("t2_lock_before", block_lock_out, 0);
        send_good(1);
        chk("t2_relock", block_lock_out, 1);

        // 3: window with 15 bad headers survives. In the next window the
        //    16th bad header is at position 40.
        s0 = slip_seen;
        for (int i = 0; i < 64; i++) begin
            maybe_idle();
            if (i % 4 == 1 && i < 60) send_bad();
            else send(1'b1, (i % 2) ? 2'b10 : 2'b01);
        end
        chk("t3_window1_lock", block_lock_out, 1);
        chk("t3_window1_noslip", slip_seen - s0, 0);
        for (int i = 0; i < 39; i++) begin
            maybe_idle();
            if (i % 2 == 0 && i < 30) send_bad();
            else send(1'b1, 2'b01);
        end
        chk("t3_pos39_lock", block_lock_out, 1);
        send_bad();
        chk("t3_pos40_lock", block_lock_out, 0);
        chk("t3_pos40_slip", slip_out, 1);
        for (int i = 0; i < SLIP_WAIT; i++) send(1'b1, 2'($urandom));
        send_good(64);
        chk("t3_relock", block_lock_out, 1);

        // 4: 16th bad header is also the last header of the window
        for (int i = 0; i < 63; i++) begin
            maybe_idle();
            if (i % 4 == 2 && i < 62) send_bad();
            else send(1'b1, 2'b10);
        end
        chk("t4_pos63_lock", block_lock_out, 1);
        send_bad();
        chk("t4_loss_wins", block_lock_out, 0);
        chk("t4_slip", slip_out, 1);

        // Random traffic: blocks of 200 cycles at varying error rates
        for (int blk = 0; blk < 15; blk++) begin
            case ($urandom_range(0, 3))
                0:       rate = 0;
                1:       rate = 10;
                2:       rate = 120;
                default: rate = 400;
            endcase
            for (int c = 0; c < 200; c++) begin
                rv = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 999) < rate)
                    rh = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                else
                    rh = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                send(rv, rh);
            end
        end

        // 5: continuous bad headers saturate the slip counter. Then an async
        //    reset arrives in the middle of the settle time.
        do_reset();
        repeat (1600) send(1'b1, 2'b11);  // 5 cycles per slip -> 320 slips
        chk("t5_saturated", slip_count_out, 255);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            send(1'b1, 2'b11);
            if (slip_out) found = 1;
        end
        chk("t5_slip_found", found, 1);
        send(1'b1, 2'b11);                // now inside the settle time
        #2;
        rx_rst = 1'b1;
        #1;
        chk("t5_async_slip",  slip_out,       0);
        chk("t5_async_lock",  block_lock_out, 0);
        chk("t5_async_dec",   dec_enable_out, 0);
        chk("t5_async_count", slip_count_out, 0);
        chk("t5_async_hiber", hi_ber_out,     0);
        hdr_valid_in = 1'b0;
        @(negedge rx_clk);
        @(negedge rx_clk);
        rx_rst = 1'b0;
        send_good(64);
        chk("t5_lock_after_rst", block_lock_out, 1);

`ifdef PCS_HI_BER_EN
        // 6: sparse errors (<16 per lock window, >=16 per BER period)
        do_reset();
        send_good(64);
        d0 = lock_drops;
        h0 = hiber_seen;
        for (int i = 0; i < 300; i++) begin
            if (i % 6 == 3) send(1'b1, 2'b00);
            else send(1'b1, 2'b01);
        end
        chk("t6_hiber_raised", (hiber_seen > h0) ? 1 : 0, 1);
        chk("t6_lock_kept", lock_drops - d0, 0);
        send_good(300);
        chk("t6_hiber_cleared", hi_ber_out, 0);
        chk("t6_dec_back", dec_enable_out, 1);
`else
        d0 = 0;
        h0 = hiber_seen;
        chk("t6_hiber_never", hiber_seen - h0 + d0, 0);
`endif

        @(negedge rx_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
